// File: rtl/reg_dump_scanner_if.sv
// rtl/reg_dump_scanner_if.sv - character write channel from the register dump scanner to a text plotter
interface reg_dump_scanner_if #(
  parameter int ADDR_W = 9
);
  logic [6:0]        char_x;
  logic [ADDR_W-1:0] char_y;
  logic [7:0]        char_code;
  logic              char_valid;
  logic              char_ready;

  modport master (
    output char_x,
    output char_y,
    output char_code,
    output char_valid,
    input  char_ready
  );

  modport slave (
    input  char_x,
    input  char_y,
    input  char_code,
    input  char_valid,
    output char_ready
  );
endinterface

// File: rtl/reg_dump_scanner.sv
// rtl/reg_dump_scanner.sv - scans a register bank and plots each value as a row of uppercase hex text; REG_DUMP_LABEL_EN adds "Rnn:" row labels
module reg_dump_scanner #(
  parameter int NUM_REGS   = 16,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 9,
  parameter int READ_LAT   = 1,
  parameter int CONTINUOUS = 0
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              start,
  input  logic [DATA_W-1:0] register_value,
  output logic [ADDR_W-1:0] addr,
  output logic              finished_register,
  output logic              busy,
  output logic              pass_done,
  reg_dump_scanner_if.master chr
);

  localparam int NDIG = DATA_W / 4;
`ifdef REG_DUMP_LABEL_EN
  localparam int LABEL_N = 4;
  localparam int COL0    = 5;
`else
  localparam int LABEL_N = 0;
  localparam int COL0    = 0;
`endif
  localparam int NCHARS = LABEL_N + NDIG;

  localparam logic [4:0]        LAST_POS  = 5'(NCHARS - 1);
  localparam logic [4:0]        LABEL_LEN = 5'(LABEL_N);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
  localparam logic [2:0]        LAT_LAST  = 3'((READ_LAT == 0) ? 0 : READ_LAT - 1);
  localparam logic [6:0]        TOP_SHIFT = 7'(4 * (NDIG - 1));
  localparam logic [6:0]        COL0_X    = 7'(COL0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_CAPTURE,
    S_EMIT,
    S_NEXT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [2:0]        wait_q, wait_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [4:0]        pos_q, pos_d;

  // Character position pos_q counts label characters first, then hex digits.
  logic [4:0] digit_idx;
  logic [6:0] shift_amt;
  logic [3:0] nibble;
  logic [7:0] hex_code;

  assign digit_idx = pos_q - LABEL_LEN;
  assign shift_amt = TOP_SHIFT - {digit_idx, 2'b00};
  assign nibble    = 4'(shadow_q >> shift_amt);
  assign hex_code  = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble})
                                      : (8'h37 + {4'h0, nibble});

`ifdef REG_DUMP_LABEL_EN
  // Decimal row label wraps every hundred rows.
  logic [6:0] row_mod;
  logic [7:0] tens_code;
  logic [7:0] units_code;

  assign row_mod    = 7'(32'(index_q) % 32'd100);
  assign tens_code  = 8'h30 + 8'(row_mod / 7'd10);
  assign units_code = 8'h30 + 8'(row_mod % 7'd10);
`endif

  // State register; reset abandons any pass and clears the capture path.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      index_q  <= '0;
      wait_q   <= '0;
      shadow_q <= '0;
      pos_q    <= '0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      wait_q   <= wait_d;
      shadow_q <= shadow_d;
      pos_q    <= pos_d;
    end
  end

  // Next-state logic: address, wait out read latency, capture, emit characters, advance.
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    wait_d   = wait_q;
    shadow_d = shadow_q;
    pos_d    = pos_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          index_d = '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        wait_d  = '0;
        state_d = (READ_LAT == 0) ? S_CAPTURE : S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == LAT_LAST) begin
          state_d = S_CAPTURE;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      S_CAPTURE: begin
        shadow_d = register_value;
        pos_d    = '0;
        state_d  = S_EMIT;
      end
      S_EMIT: begin
        if (chr.char_ready) begin
          if (pos_q == LAST_POS) begin
            state_d = S_NEXT;
          end else begin
            pos_d = pos_q + 5'd1;
          end
        end
      end
      S_NEXT: begin
        if (index_q != LAST_IDX) begin
          index_d = index_q + 1'b1;
          state_d = S_ADDR;
        end else if (CONTINUOUS != 0) begin
          index_d = '0;
          state_d = S_ADDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Character outputs are decoded from registered state so they hold while stalled.
  always_comb begin
    chr.char_valid = 1'b0;
    chr.char_x     = '0;
    chr.char_y     = '0;
    chr.char_code  = '0;
    if (state_q == S_EMIT) begin
      chr.char_valid = 1'b1;
      chr.char_y     = index_q;
      chr.char_x     = COL0_X + {2'b00, digit_idx};
      chr.char_code  = hex_code;
`ifdef REG_DUMP_LABEL_EN
      if (pos_q < LABEL_LEN) begin
        chr.char_x = {2'b00, pos_q};
        case (pos_q[1:0])
          2'd0:    chr.char_code = 8'h52;
          2'd1:    chr.char_code = tens_code;
          2'd2:    chr.char_code = units_code;
          default: chr.char_code = 8'h3A;
        endcase
      end
`endif
    end
  end

  assign addr              = index_q;
  assign busy              = (state_q != S_IDLE);
  assign finished_register = (state_q == S_NEXT);
  assign pass_done         = (state_q == S_NEXT) && (index_q == LAST_IDX);

endmodule

// File: tb/tb_reg_dump_scanner.sv
// tb/tb_reg_dump_scanner.sv - randomized self-checking bench for reg_dump_scanner
module tb_reg_dump_scanner;
  localparam int AW = 9;
`ifdef REG_DUMP_LABEL_EN
  localparam int LBL  = 4;
  localparam int COL0 = 5;
`else
  localparam int LBL  = 0;
  localparam int COL0 = 0;
`endif

  typedef logic [23:0] ent_t;
  typedef ent_t ent_q_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn0, rstn1, start0, start1;
  logic [31:0]   rv0;
  logic [15:0]   rv1, p1, p2;
  logic [AW-1:0] addr0, addr1;
  logic          fin0, fin1, busy0, busy1, pd0, pd1;
  logic          rdy_mode0, rdy_mode1;
  logic [15:0]   lfsr;
  logic [31:0]   mem0 [16];
  logic [15:0]   mem1 [4];

  reg_dump_scanner_if #(.ADDR_W(AW)) c0 ();
  reg_dump_scanner_if #(.ADDR_W(AW)) c1 ();

  reg_dump_scanner #(
    .NUM_REGS(16), .DATA_W(32), .ADDR_W(AW), .READ_LAT(1), .CONTINUOUS(0)
  ) dut0 (
    .CLOCK_50(clk), .resetn(rstn0), .start(start0), .register_value(rv0),
    .addr(addr0), .finished_register(fin0), .busy(busy0), .pass_done(pd0),
    .chr(c0)
  );

  reg_dump_scanner #(
    .NUM_REGS(4), .DATA_W(16), .ADDR_W(AW), .READ_LAT(3), .CONTINUOUS(1)
  ) dut1 (
    .CLOCK_50(clk), .resetn(rstn1), .start(start1), .register_value(rv1),
    .addr(addr1), .finished_register(fin1), .busy(busy1), .pass_done(pd1),
    .chr(c1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Register bank with read latency; while characters are emitted the bus carries junk.
  always @(posedge clk) begin
    rv0 <= c0.char_valid ? $urandom : mem0[addr0[3:0]];
    p1  <= c1.char_valid ? 16'($urandom) : mem1[addr1[1:0]];
    p2  <= p1;
    rv1 <= p2;
  end

  // Ready generator.
  initial begin
    lfsr = 16'hACE1;
    c0.char_ready = 1'b1;
    c1.char_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      c0.char_ready = rdy_mode0 ? lfsr[0] : 1'b1;
      c1.char_ready = rdy_mode1 ? lfsr[5] : 1'b1;
    end
  end

  // Monitors: collect transfers, count pulses, check stall stability.
  ent_q_t q0, q1;
  int fin_cnt0 = 0, fin_cnt1 = 0, pd_cnt0 = 0, pd_cnt1 = 0;
  logic stall0 = 1'b0, stall1 = 1'b0, chk_addr1 = 1'b0;
  ent_t last0, last1;

  always @(negedge clk) begin
    if (rstn0 === 1'b1) begin
      if (stall0)
        check_val("stall_hold0", {c0.char_valid, c0.char_y, c0.char_x, c0.char_code}, {1'b1, last0});
      if (c0.char_valid && c0.char_ready) q0.push_back({c0.char_y, c0.char_x, c0.char_code});
      stall0 = c0.char_valid && !c0.char_ready;
      last0  = {c0.char_y, c0.char_x, c0.char_code};
      if (fin0) fin_cnt0++;
      if (pd0) pd_cnt0++;
    end else begin
      stall0 = 1'b0;
    end
    if (rstn1 === 1'b1) begin
      if (stall1)
        check_val("stall_hold1", {c1.char_valid, c1.char_y, c1.char_x, c1.char_code}, {1'b1, last1});
      if (chk_addr1) begin
        check_val("addr_wrap1", addr1, 0);
        chk_addr1 = 1'b0;
      end
      if (c1.char_valid && c1.char_ready) q1.push_back({c1.char_y, c1.char_x, c1.char_code});
      stall1 = c1.char_valid && !c1.char_ready;
      last1  = {c1.char_y, c1.char_x, c1.char_code};
      if (fin1) fin_cnt1++;
      if (pd1) begin
        pd_cnt1++;
        chk_addr1 = 1'b1;
      end
    end else begin
      stall1 = 1'b0;
      chk_addr1 = 1'b0;
    end
  end

  // Reference: the text a whole pass should plot, row by row.
  function automatic ent_q_t model_pass(input int which);
    ent_q_t r;
    string hexd = "0123456789ABCDEF";
    int nregs = (which == 0) ? 16 : 4;
    int ndig  = (which == 0) ? 8 : 4;
    for (int i = 0; i < nregs; i++) begin
      logic [63:0] v;
      v = (which == 0) ? 64'(mem0[i]) : 64'(mem1[i]);
      if (LBL != 0) begin
        r.push_back({9'(i), 7'd0, 8'h52});
        r.push_back({9'(i), 7'd1, 8'(48 + (i % 100) / 10)});
        r.push_back({9'(i), 7'd2, 8'(48 + (i % 10))});
        r.push_back({9'(i), 7'd3, 8'h3A});
      end
      for (int d = 0; d < ndig; d++) begin
        int n;
        n = int'((v >> (4 * (ndig - 1 - d))) & 64'hF);
        r.push_back({9'(i), 7'(COL0 + d), 8'(hexd[n])});
      end
    end
    return r;
  endfunction

  task automatic cmp_stream(input string tag, input ent_q_t got, input ent_q_t exp, input int offs);
    for (int i = 0; i < exp.size(); i++)
      check_val($sformatf("%s_char%0d", tag, i),
                (got.size() > i + offs) ? got[i + offs] : 'x, exp[i]);
  endtask

  task automatic start_pulse(input int which, output int lat);
    @(posedge clk);
    #1;
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    lat = 1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if ((which == 0) ? c0.char_valid : c1.char_valid) break;
      lat++;
    end
  endtask

  task automatic wait_idle0(input string tag);
    int k = 0;
    while (busy0 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (busy0) check_val({tag, "_timeout"}, 0, 1);
  endtask

  task automatic run_pass0(input string tag, input bit mid_start);
    int lat;
    ent_q_t e;
    q0.delete();
    fin_cnt0 = 0;
    pd_cnt0  = 0;
    start_pulse(0, lat);
    check_val({tag, "_latency"}, lat, 4);
    check_val({tag, "_busy_hi"}, busy0, 1);
    if (mid_start) begin
      repeat (20) @(posedge clk);
      #1 start0 = 1'b1;
      @(posedge clk);
      #1 start0 = 1'b0;
    end
    wait_idle0(tag);
    e = model_pass(0);
    check_val({tag, "_len"}, q0.size(), e.size());
    cmp_stream(tag, q0, e, 0);
    check_val({tag, "_fin_cnt"}, fin_cnt0, 16);
    check_val({tag, "_pass_done_cnt"}, pd_cnt0, 1);
    check_val({tag, "_busy_lo"}, busy0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    int k;
    int idx_c;
    ent_q_t e;
    rstn0 = 1'b0; rstn1 = 1'b0; start0 = 1'b0; start1 = 1'b0;
    rdy_mode0 = 1'b0; rdy_mode1 = 1'b0;
    for (int i = 0; i < 16; i++) mem0[i] = 32'h12345678;
    for (int i = 0; i < 4; i++) mem1[i] = 16'($urandom);
    mem1[2] = 16'hABCD;

    repeat (3) @(negedge clk);
    check_val("reset_dut0", {addr0, c0.char_x, c0.char_y, c0.char_code, c0.char_valid, fin0, busy0, pd0}, 0);
    check_val("reset_dut1", {addr1, c1.char_x, c1.char_y, c1.char_code, c1.char_valid, fin1, busy1, pd1}, 0);
    rstn0 = 1'b1;
    rstn1 = 1'b1;
    #1 check_val("hold_after_release", {addr0, c0.char_valid, c0.char_code, busy0, pd0}, 0);

    run_pass0("pass_const", 1'b0);

    rdy_mode0 = 1'b1;
    for (int i = 0; i < 16; i++) mem0[i] = $urandom;
    run_pass0("pass_lfsr", 1'b1);
    for (int i = 0; i < 16; i++) mem0[i] = $urandom;
    run_pass0("pass_lfsr2", 1'b0);

    // Reset in the middle of row 5.
    for (int i = 0; i < 16; i++) mem0[i] = $urandom;
    q0.delete();
    fin_cnt0 = 0;
    pd_cnt0  = 0;
    start_pulse(0, lat);
    k = 0;
    while (!(c0.char_valid && c0.char_y == 9'd5) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check_val("reach_row5", {c0.char_valid, c0.char_y}, {1'b1, 9'd5});
    #2 rstn0 = 1'b0;
    #1 check_val("async_reset_outs", {addr0, c0.char_x, c0.char_y, c0.char_code, c0.char_valid, fin0, busy0, pd0}, 0);
    check_val("fin_before_reset", fin_cnt0, 5);
    repeat (3) @(negedge clk);
    #2 rstn0 = 1'b1;
    repeat (5) @(negedge clk);
    check_val("no_pulse_after_reset", {fin_cnt0, pd_cnt0}, {32'd5, 32'd0});
    check_val("idle_without_start", busy0, 0);
    rdy_mode0 = 1'b0;
    run_pass0("pass_after_reset", 1'b0);
    check_val("restart_row0", (q0.size() > 0) ? q0[0][23:15] : 'x, 0);

    // Continuous scanner with 16-bit registers and three cycles of read latency.
    q1.delete();
    fin_cnt1 = 0;
    pd_cnt1  = 0;
    start_pulse(1, lat);
    check_val("lat_dut1", lat, 6);
    repeat (10) @(posedge clk);
    #1 start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    k = 0;
    while (pd_cnt1 < 2 && k < 3000) begin
      @(posedge clk);
      #2;
      k++;
    end
    check_val("dut1_two_passes", pd_cnt1, 2);
    e = model_pass(1);
    check_val("dut1_len", q1.size(), 2 * e.size());
    cmp_stream("dut1_pass1", q1, e, 0);
    cmp_stream("dut1_pass2", q1, e, e.size());
    check_val("dut1_fin_cnt", fin_cnt1, 8);
    idx_c = 2 * (LBL + 4) + LBL + 2;
    check_val("dut1_row2_C", (q1.size() > idx_c) ? q1[idx_c] : 'x, {9'd2, 7'(COL0 + 2), 8'h43});
    repeat (3) @(negedge clk);
    check_val("dut1_still_busy", busy1, 1);
    rstn1 = 1'b0;
    #1 check_val("dut1_reset_busy", busy1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
